// File: rtl/gps_launch_sequencer.sv
// Armed trigger sequencer: waits for an immediate, next-PPS or GPS-time-matched
// start event, then fires N_CH enable-masked, independently delayed START levels.

module gps_launch_ch #(
  parameter int DLY_W = 24
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             dly_we_i,
  input  logic [DLY_W-1:0] dly_wdata_i,
  input  logic [DLY_W-1:0] cnt_i,
  input  logic             run_i,
  input  logic             en_i,
  input  logic             clr_i,
  output logic             start_o
);
  logic [DLY_W-1:0] dly_q;
  logic             start_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      dly_q   <= '0;
      start_q <= 1'b0;
    end else begin
      if (dly_we_i) dly_q <= dly_wdata_i;
      if (clr_i)
        start_q <= 1'b0;
      else if (run_i && en_i && cnt_i == dly_q)
        start_q <= 1'b1;
    end
  end

  assign start_o = start_q;
endmodule

module gps_launch_sequencer #(
  parameter int          N_CH        = 4,
  parameter logic [15:0] BASE_ADDR   = 16'd200,
  parameter int          DLY_W       = 24,
  parameter int          SYNC_STAGES = 2
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            TR,
  input  logic [15:0]     ADDR,
  input  logic [31:0]     DATA,
  input  logic            GPS_1PPS,
  input  logic            GPS_locked,
  input  logic [55:0]     GPS_time,
  output logic [N_CH-1:0] START,
  output logic            BUSY,
  output logic            ARMED,
  output logic            DONE,
  output logic            MISSED
);
  typedef enum logic [2:0] {S_IDLE, S_WAIT_PPS, S_WAIT_TIME, S_DLY, S_FIRED} state_t;

  state_t                 state_q;
  logic [DLY_W-1:0]       cnt_q;
  logic                   missed_q;
  logic [SYNC_STAGES-1:0] tr_sync_q, pps_sync_q;
  logic                   tr_last_q, pps_last_q;
  logic [1:0]             mode_q;
  logic [31:0]            tgt_date_q;
  logic [23:0]            tgt_tod_q;
  logic [N_CH-1:0]        ch_en_q;
  logic [N_CH-1:0]        start_w;

  logic        wr_stb, pps_stb, in_range, cfg_we, ctrl_wr, arm, abort;
  logic [15:0] off;

  // Async strobes: synchroniser chains plus rising-edge detect on the last stage.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tr_sync_q  <= '0;
      pps_sync_q <= '0;
      tr_last_q  <= 1'b0;
      pps_last_q <= 1'b0;
    end else begin
      tr_sync_q  <= {tr_sync_q[SYNC_STAGES-2:0], TR};
      pps_sync_q <= {pps_sync_q[SYNC_STAGES-2:0], GPS_1PPS};
      tr_last_q  <= tr_sync_q[SYNC_STAGES-1];
      pps_last_q <= pps_sync_q[SYNC_STAGES-1];
    end
  end

  assign wr_stb   = tr_sync_q[SYNC_STAGES-1] & ~tr_last_q;
  assign pps_stb  = pps_sync_q[SYNC_STAGES-1] & ~pps_last_q;
  assign off      = ADDR - BASE_ADDR;
  assign in_range = (ADDR >= BASE_ADDR);
  assign cfg_we   = wr_stb && in_range && (state_q == S_IDLE);
  assign ctrl_wr  = wr_stb && in_range && (off == 16'd0);
  assign abort    = ctrl_wr && DATA[1];
  assign arm      = ctrl_wr && DATA[0] && !DATA[1];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mode_q     <= '0;
      tgt_date_q <= '0;
      tgt_tod_q  <= '0;
      ch_en_q    <= '0;
    end else if (cfg_we) begin
      case (off)
        16'd1:   mode_q     <= DATA[1:0];
        16'd2:   tgt_date_q <= DATA;
        16'd3:   tgt_tod_q  <= DATA[23:0];
        16'd4:   ch_en_q    <= DATA[N_CH-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      missed_q <= 1'b0;
    end else if (abort) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      cnt_q <= '0;
      case (state_q)
        S_IDLE: if (arm) begin
          missed_q <= 1'b0;
          case (mode_q)
            2'd1:    state_q <= S_DLY;
            2'd2:    state_q <= S_WAIT_TIME;
            2'd3:    state_q <= S_WAIT_PPS;
            default: state_q <= S_IDLE;
          endcase
        end
        S_WAIT_PPS: if (pps_stb && GPS_locked) state_q <= S_DLY;
        S_WAIT_TIME: if (pps_stb && GPS_locked) begin
          if (GPS_time == {tgt_date_q, tgt_tod_q})
            state_q <= S_DLY;
          else if (GPS_time > {tgt_date_q, tgt_tod_q}) begin
            missed_q <= 1'b1;
            state_q  <= S_IDLE;
          end
        end
        S_DLY: begin
          cnt_q <= (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
          // Registered START feeds back, so FIRED lands one cycle after the last set.
          if ((start_w & ch_en_q) == ch_en_q) state_q <= S_FIRED;
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    gps_launch_ch #(.DLY_W(DLY_W)) u_ch (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .dly_we_i   (cfg_we && off == 16'(8 + i)),
      .dly_wdata_i(DATA[DLY_W-1:0]),
      .cnt_i      (cnt_q),
      .run_i      (state_q == S_DLY),
      .en_i       (ch_en_q[i]),
      .clr_i      (abort || state_q == S_IDLE),
      .start_o    (start_w[i])
    );
  end

  assign START  = start_w;
  assign BUSY   = (state_q != S_IDLE);
  assign ARMED  = (state_q == S_WAIT_PPS) || (state_q == S_WAIT_TIME);
  assign DONE   = (state_q == S_FIRED);
  assign MISSED = missed_q;
endmodule

// File: doc/gps_launch_sequencer.md
Name: gps_launch_sequencer

Overview:
- Next-generation probe launcher: a bus-configured trigger sequencer that arms on command and waits for a start event. The start event is immediate, the next GPS 1PPS edge, or a 1PPS edge at a programmed GPS time.
- After the event, it fires N_CH independently delayed, enable-masked START outputs.
- Sits between the host register bus (TR/ADDR/DATA) and the probe/DDS channels.
- All logic is in the CLK domain; TR and GPS_1PPS are synchronised internally.

Parameters:
N_CH, 4, number of START channels (1..16)
BASE_ADDR, 16'd200, first register address
DLY_W, 24, width of per-channel delay counter in CLK cycles
SYNC_STAGES, 2, synchroniser depth for TR and GPS_1PPS (>=2)

Ports:
CLK  in  1  system clock
RESET_N  in  1  asynchronous active-low reset
TR  in  1  register write strobe, async; ADDR/DATA stable >= SYNC_STAGES+2 CLK after TR rises
ADDR  in  16  register address
DATA  in  32  write data
GPS_1PPS  in  1  GPS pulse-per-second, async
GPS_locked  in  1  GPS lock valid
GPS_time  in  56  {year[55:40], month[39:32], day[31:24], hour[23:16], min[15:8], sec[7:0]}, time of second starting at current PPS
START  out  N_CH  per-channel launch level
BUSY  out  1  state != IDLE
ARMED  out  1  state is WAIT_PPS or WAIT_TIME
DONE  out  1  state is FIRED
MISSED  out  1  sticky: target time passed without match

Behaviour:
- Reset: RESET_N is asynchronous, active-low; clock is CLK. On reset, all registers, the counter and the FSM (IDLE) clear; every output is 0.
- Write capture: TR passes through a SYNC_STAGES flop chain; a rising-edge detect produces wr_stb. ADDR/DATA are sampled on wr_stb. A register updates SYNC_STAGES+1 CLK cycles after TR rises. Unmapped addresses are ignored.
- Register map (offset from BASE_ADDR):
  - +0 CTRL: bit0 ARM and bit1 ABORT, both write-only pulses. ABORT wins if both are set.
  - +1 MODE[1:0]: 0 disabled, 1 immediate, 2 GPS time match, 3 next PPS.
  - +2 TGT_DATE: {year[31:16], month[15:8], day[7:0]}.
  - +3 TGT_TOD: {hour[23:16], min[15:8], sec[7:0]}.
  - +4 CH_EN[N_CH-1:0].
  - +8+i CH_DLY[i][DLY_W-1:0], for i < N_CH.
- Config lock: writes to +1..+(8+N_CH-1) are ignored while BUSY. CTRL is always accepted.
- PPS: GPS_1PPS is synchronised and edge-detected into pps_stb (one CLK). GPS_time is sampled on pps_stb.
- FSM:
  - IDLE: START=0. ARM clears MISSED, then by MODE: 1 -> DLY, 3 -> WAIT_PPS, 2 -> WAIT_TIME, 0 -> stay in IDLE.
  - WAIT_PPS: pps_stb && GPS_locked -> DLY.
  - WAIT_TIME: on pps_stb && GPS_locked, compare GPS_time with {TGT_DATE, TGT_TOD} as 56-bit unsigned values.
    - equal -> DLY.
    - GPS_time greater -> set MISSED, go to IDLE.
    - less -> stay.
    - pps_stb with GPS_locked=0 -> stay, no comparison.
  - DLY: cnt=0 in the first DLY cycle, +1 per cycle, saturating at all-ones.
    - When cnt==CH_DLY[i] and CH_EN[i], START[i] is set (registered, sticky). START[i] therefore rises CH_DLY[i]+1 cycles after DLY entry.
    - Go to FIRED the cycle after the last enabled channel sets.
    - CH_EN==0 -> FIRED on the cycle after entry, with no START.
  - FIRED: START is held. ARM is ignored.
  - ABORT in any state: IDLE on the next cycle, all START cleared, cnt cleared. MISSED is unaffected.
- Disabled channels never assert START.
- Equal delays on several channels: those channels assert in the same cycle.
- Reset mid-sequence: immediate return to IDLE with START=0. Config registers revert to 0.

Test Plan:
- Reset, then write MODE=1, CH_EN=4'b0101, CH_DLY0=0, CH_DLY2=10, then CTRL=1 -> START[0] rises 1 cycle after DLY entry and START[2] 11 cycles after; START[1], START[3] stay 0; DONE=1; BUSY stays 1.
- MODE=3, GPS_locked=0, ARM, one PPS -> ARMED stays 1. Set GPS_locked=1, next PPS -> DLY entered; START[0] rises CH_DLY0+1 cycles after synchronised PPS edge.
- MODE=2, target 2024-06-01 12:00:05; feed PPS with seconds 03, 04, 05 -> fires only after the sec=05 PPS. Repeat with first PPS at sec=06 -> MISSED=1, BUSY=0, START=0.
- While in WAIT_TIME, write CH_DLY0=99 -> value unchanged on readback/behaviour. Write CTRL=3 (ARM+ABORT) -> IDLE, START=0.
- In FIRED, write CTRL=2 -> all START drop the cycle after capture. Then ARM again -> sequence repeats identically.
- Assert RESET_N low mid-DLY with cnt=5 -> START, BUSY, DONE, MISSED are 0 asynchronously; MODE reads 0 after release.
